iic_master: RTL and testbench

IIC_MASTER -- requirements
Module: iic_master

---
 rtl/iic_master.sv | 192 +++++++++++++++++++
 tb/tb_iic_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_master.sv
// Single-master I2C engine: START, 7-bit address + R/W, one data byte, STOP.
// Quarter-period timing, clock stretching on SCL high phases, arbitration loss detection.
module iic_master #(
  parameter int unsigned word_width  = 8,
  parameter int unsigned quarter_div = 4
) (
  input  logic                  clk,
  input  logic                  NRST,
  input  logic                  REQ,
  input  logic [6:0]            ADDR,
  input  logic                  RW,
  input  logic [word_width-1:0] D_IN,
  output logic [word_width-1:0] D_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  NACK,
  output logic                  ARB_LOST,
  input  logic                  SDA_IN,
  input  logic                  SCL_IN,
  output logic                  SDA_OUT,
  output logic                  SCL_OUT
);

  localparam int unsigned QW = (quarter_div > 1) ? $clog2(quarter_div) : 1;
  localparam logic [QW-1:0] QLOAD = QW'(quarter_div - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR, ST_ADDR_ACK, ST_WRITE,
    ST_WRITE_ACK, ST_READ, ST_READ_ACK, ST_STOP
  } state_t;

  state_t                state;
  logic [QW-1:0]         qcnt;
  logic [1:0]            phase;
  logic [2:0]            bitcnt;
  logic [7:0]            tx;
  logic [7:0]            rx;
  logic                  rw_q;
  logic [word_width-1:0] data_q;
  logic                  in_slot;
  logic                  stall;

  // The quarter counter freezes while SCL is released but a slave still holds it low.
  always_comb begin
    in_slot = (state == ST_ADDR) || (state == ST_ADDR_ACK) || (state == ST_WRITE) ||
              (state == ST_WRITE_ACK) || (state == ST_READ) || (state == ST_READ_ACK);
    stall   = SCL_OUT && !SCL_IN &&
              ((in_slot && phase == 2'd2) || (state == ST_STOP && phase == 2'd1));
  end

  always_ff @(posedge clk) begin
    if (!NRST) begin
      state    <= ST_IDLE;
      qcnt     <= '0;
      phase    <= '0;
      bitcnt   <= '0;
      tx       <= '0;
      rx       <= '0;
      rw_q     <= 1'b0;
      data_q   <= '0;
      D_OUT    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      NACK     <= 1'b0;
      ARB_LOST <= 1'b0;
      SDA_OUT  <= 1'b1;
      SCL_OUT  <= 1'b1;
    end else begin
      DONE <= 1'b0;
      if (state == ST_IDLE) begin
        SDA_OUT <= 1'b1;
        SCL_OUT <= 1'b1;
        if (REQ) begin
          tx       <= {ADDR, RW};
          rw_q     <= RW;
          data_q   <= D_IN;
          NACK     <= 1'b0;
          ARB_LOST <= 1'b0;
          BUSY     <= 1'b1;
          qcnt     <= QLOAD;
          phase    <= '0;
          state    <= ST_START;
        end
      end else if (!stall) begin
        if (qcnt != '0) begin
          qcnt <= qcnt - QW'(1);
        end else begin
          qcnt <= QLOAD;
          case (state)
            ST_START: begin
              if (phase == 2'd0) begin
                phase   <= 2'd1;
                SDA_OUT <= 1'b0;
              end else begin
                phase   <= '0;
                bitcnt  <= '0;
                SCL_OUT <= 1'b0;
                SDA_OUT <= tx[7];
                state   <= ST_ADDR;
              end
            end
            ST_STOP: begin
              case (phase)
                2'd0: begin
                  phase   <= 2'd1;
                  SCL_OUT <= 1'b1;
                end
                2'd1: begin
                  phase   <= 2'd2;
                  SDA_OUT <= 1'b1;
                end
                default: begin
                  phase <= '0;
                  qcnt  <= '0;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  state <= ST_IDLE;
                end
              endcase
            end
            default: begin
              case (phase)
                2'd0: phase <= 2'd1;
                2'd1: begin
                  phase   <= 2'd2;
                  SCL_OUT <= 1'b1;
                end
                2'd2: begin
                  phase <= 2'd3;
                  if (state == ST_READ) rx <= {rx[6:0], SDA_IN};
                  if ((state == ST_ADDR_ACK || state == ST_WRITE_ACK) && SDA_IN) NACK <= 1'b1;
                  // Lost arbitration: abandon the bus immediately, no STOP.
                  if ((state == ST_ADDR || state == ST_WRITE) && SDA_OUT && !SDA_IN) begin
                    ARB_LOST <= 1'b1;
                    BUSY     <= 1'b0;
                    DONE     <= 1'b1;
                    SDA_OUT  <= 1'b1;
                    SCL_OUT  <= 1'b1;
                    phase    <= '0;
                    bitcnt   <= '0;
                    qcnt     <= '0;
                    state    <= ST_IDLE;
                  end
                end
                default: begin
                  phase   <= '0;
                  SCL_OUT <= 1'b0;
                  case (state)
                    ST_ADDR, ST_WRITE, ST_READ: begin
                      if (bitcnt != 3'd7) begin
                        bitcnt  <= bitcnt + 3'd1;
                        tx      <= {tx[6:0], 1'b0};
                        SDA_OUT <= (state == ST_READ) ? 1'b1 : tx[6];
                      end else begin
                        bitcnt  <= '0;
                        SDA_OUT <= 1'b1;
                        if (state == ST_ADDR) state <= ST_ADDR_ACK;
                        else if (state == ST_WRITE) state <= ST_WRITE_ACK;
                        else begin
                          D_OUT <= word_width'(rx);
                          state <= ST_READ_ACK;
                        end
                      end
                    end
                    ST_ADDR_ACK: begin
                      if (NACK) begin
                        SDA_OUT <= 1'b0;
                        state   <= ST_STOP;
                      end else if (rw_q) begin
                        SDA_OUT <= 1'b1;
                        state   <= ST_READ;
                      end else begin
                        tx      <= data_q[7:0];
                        SDA_OUT <= data_q[7];
                        state   <= ST_WRITE;
                      end
                    end
                    default: begin
                      SDA_OUT <= 1'b0;
                      state   <= ST_STOP;
                    end
                  endcase
                end
              endcase
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_iic_master.sv
// Bench for iic_master: wired-AND bus with a behavioural slave/monitor that decodes
// bytes on rising SCL, compared against expected byte sequences derived per transaction.
module tb_iic_master;

  localparam int Q = 2;

  logic       clk = 1'b0;
  logic       NRST = 1'b0;
  logic       REQ = 1'b0;
  logic [6:0] ADDR = '0;
  logic       RW = 1'b0;
  logic [7:0] D_IN = '0;
  logic [7:0] D_OUT;
  logic       BUSY, DONE, NACK, ARB_LOST;
  logic       SDA_IN, SCL_IN, SDA_OUT, SCL_OUT;

  logic slave_sda = 1'b1;
  logic arb_force = 1'b0;
  logic stretch = 1'b0;
  logic sda_bus, scl_bus;
  assign scl_bus = SCL_OUT & ~stretch;
  assign sda_bus = SDA_OUT & slave_sda & ~arb_force;
  assign SCL_IN  = scl_bus;
  assign SDA_IN  = sda_bus;

  iic_master #(.word_width(8), .quarter_div(Q)) dut (
    .clk(clk), .NRST(NRST), .REQ(REQ), .ADDR(ADDR), .RW(RW), .D_IN(D_IN),
    .D_OUT(D_OUT), .BUSY(BUSY), .DONE(DONE), .NACK(NACK), .ARB_LOST(ARB_LOST),
    .SDA_IN(SDA_IN), .SCL_IN(SCL_IN), .SDA_OUT(SDA_OUT), .SCL_OUT(SCL_OUT)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] dout_exp = 8'h00;

  // Slave behaviour and bus decoding.
  logic       sl_ack_addr = 1'b1, sl_ack_data = 1'b1;
  logic [7:0] sl_rd = 8'h00;
  int unsigned mon_gen = 0, mon_seen = 0;
  logic [8:0] mon_q[$];
  int start_cnt = 0, stop_cnt = 0, bitk = 0, byte_idx = 0;
  logic [7:0] cur = '0;
  logic m_rw = 1'b0, p_scl = 1'b1, p_sda = 1'b1;

  always @(negedge clk) begin
    if (mon_seen != mon_gen) begin
      mon_seen = mon_gen;
      mon_q.delete();
      start_cnt = 0; stop_cnt = 0; bitk = 0; byte_idx = 0; slave_sda = 1'b1;
    end else if (p_scl && scl_bus && p_sda && !sda_bus) begin
      start_cnt++; bitk = 0; byte_idx = 0;
    end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
      stop_cnt++; bitk = 0;
    end else if (!p_scl && scl_bus) begin
      if (bitk < 8) begin
        cur = {cur[6:0], sda_bus}; bitk++;
      end else begin
        mon_q.push_back({cur, sda_bus});
        if (byte_idx == 0) m_rw = cur[0];
        byte_idx++; bitk = 0;
      end
    end else if (p_scl && !scl_bus) begin
      slave_sda = 1'b1;
      if (bitk == 8) begin
        if (byte_idx == 0) slave_sda = !sl_ack_addr;
        else if (byte_idx == 1 && !m_rw) slave_sda = !sl_ack_data;
      end else if (byte_idx == 1 && m_rw && sl_ack_addr) begin
        slave_sda = sl_rd[3'(7 - bitk)];
      end
    end
    p_scl = scl_bus;
    p_sda = sda_bus;
  end

  task automatic run_txn(input string tag, input logic [6:0] a, input logic r, input logic [7:0] d,
                         input logic aa, input logic ad, input logic [7:0] rd, input int stretch_slot);
    logic [8:0] exp_q[$];
    logic exp_nack, got, ps;
    int rises, hi, dones;
    sl_ack_addr = aa; sl_ack_data = ad; sl_rd = rd; mon_gen++;
    @(negedge clk); ADDR = a; RW = r; D_IN = d; REQ = 1'b1;
    @(negedge clk); REQ = 1'b0; ADDR = 7'($urandom); RW = 1'($urandom); D_IN = 8'($urandom);
    vectors++;
    if (BUSY !== 1'b1) begin miscompares++; $display("FAIL %s busy: got %b expected 1", tag, BUSY); end
    if (stretch_slot > 0) begin
      rises = 0; hi = 0; ps = SCL_OUT;
      for (int i = 0; i < 1000 && hi == 0; i++) begin
        @(negedge clk);
        if (SCL_OUT && !ps) begin
          rises++;
          if (rises == stretch_slot) begin stretch = 1'b1; hi = 1; end
        end
        ps = SCL_OUT;
      end
      for (int i = 0; i < 1000 && hi != 0; i++) begin
        @(negedge clk);
        if (!SCL_OUT) break;
        hi++;
        if (hi == 11) stretch = 1'b0;
      end
      stretch = 1'b0;
      vectors++;
      if (hi !== 2*Q + 10) begin miscompares++; $display("FAIL %s scl_high_len: got %0d expected %0d", tag, hi, 2*Q+10); end
    end
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (DONE === 1'b1) begin got = 1'b1; break; end
    end
    exp_q.push_back({a, r, !aa});
    if (aa) begin
      if (!r) exp_q.push_back({d, !ad});
      else    exp_q.push_back({rd, 1'b1});
    end
    exp_nack = !aa || (!r && !ad);
    if (aa && r) dout_exp = rd;
    vectors++;
    if (got !== 1'b1) begin miscompares++; $display("FAIL %s done_timeout: got 0 expected 1", tag); end
    vectors++;
    if ({BUSY, SDA_OUT, SCL_OUT} !== 3'b011) begin
      miscompares++; $display("FAIL %s idle_lines: got busy/sda/scl %b expected 011", tag, {BUSY, SDA_OUT, SCL_OUT});
    end
    vectors++;
    if (mon_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL %s byte_count: got %0d expected %0d", tag, mon_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < mon_q.size()) begin
        vectors++;
        if (mon_q[k] !== exp_q[k]) begin
          miscompares++; $display("FAIL %s byte%0d {data,ack}: got %h expected %h", tag, k, mon_q[k], exp_q[k]);
        end
      end
    end
    vectors++;
    if ({NACK, ARB_LOST} !== {exp_nack, 1'b0}) begin
      miscompares++; $display("FAIL %s nack/arb: got %b expected %b", tag, {NACK, ARB_LOST}, {exp_nack, 1'b0});
    end
    vectors++;
    if (D_OUT !== dout_exp) begin miscompares++; $display("FAIL %s d_out: got %h expected %h", tag, D_OUT, dout_exp); end
    vectors++;
    if (start_cnt !== 1 || stop_cnt !== 1) begin
      miscompares++; $display("FAIL %s start/stop: got %0d/%0d expected 1/1", tag, start_cnt, stop_cnt);
    end
    dones = 1;
    repeat (4) begin @(negedge clk); if (DONE === 1'b1) dones++; end
    vectors++;
    if (dones !== 1) begin miscompares++; $display("FAIL %s done_pulses: got %0d expected 1", tag, dones); end
  endtask

  task automatic test_reset();
    NRST = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({SDA_OUT, SCL_OUT, BUSY, DONE, NACK, ARB_LOST, D_OUT} !== {6'b110000, 8'h00}) begin
      miscompares++; $display("FAIL reset_state: got %b expected %b",
        {SDA_OUT, SCL_OUT, BUSY, DONE, NACK, ARB_LOST, D_OUT}, {6'b110000, 8'h00});
    end
    NRST = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    run_txn("write", 7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0);
  endtask

  task automatic test_read();
    run_txn("read", 7'h28, 1'b1, 8'($urandom), 1'b1, 1'b1, 8'h3C, 0);
  endtask

  task automatic test_addr_nack();
    run_txn("addr_nack", 7'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b1, 8'($urandom), 0);
  endtask

  task automatic test_data_nack();
    run_txn("data_nack", 7'($urandom), 1'b0, 8'($urandom), 1'b1, 1'b0, 8'h00, 0);
  endtask

  task automatic test_stretch();
    run_txn("stretch", 7'($urandom), 1'b0, 8'($urandom), 1'b1, 1'b1, 8'h00, 3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      run_txn("random", 7'($urandom), 1'($urandom), 8'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 8'($urandom), 0);
  endtask

  task automatic test_arbitration();
    logic got, quiet;
    int cyc;
    sl_ack_addr = 1'b1; sl_ack_data = 1'b1; mon_gen++;
    @(negedge clk); ADDR = 7'($urandom) | 7'h40; RW = 1'($urandom); D_IN = 8'($urandom); REQ = 1'b1;
    @(negedge clk); REQ = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (SCL_OUT === 1'b0) begin got = 1'b1; break; end
    end
    arb_force = 1'b1;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); cyc++;
      if (DONE === 1'b1) break;
    end
    vectors++;
    if (got !== 1'b1 || cyc !== 3*Q) begin
      miscompares++; $display("FAIL arb_latency: got %0d cycles expected %0d", cyc, 3*Q);
    end
    vectors++;
    if ({ARB_LOST, SDA_OUT, SCL_OUT, BUSY, NACK} !== 5'b11100) begin
      miscompares++; $display("FAIL arb_state: got %b expected 11100", {ARB_LOST, SDA_OUT, SCL_OUT, BUSY, NACK});
    end
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (!SDA_OUT || !SCL_OUT || BUSY || DONE) quiet = 1'b0;
    end
    vectors++;
    if (quiet !== 1'b1) begin miscompares++; $display("FAIL arb_no_stop: got activity expected released bus"); end
    arb_force = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [6:0] a1, a2;
    logic [7:0] d1, rd;
    logic got;
    a1 = 7'($urandom); a2 = 7'($urandom); d1 = 8'($urandom); rd = 8'($urandom);
    sl_ack_addr = 1'b1; sl_ack_data = 1'b1; sl_rd = rd; mon_gen++;
    @(negedge clk); ADDR = a1; RW = 1'b0; D_IN = d1; REQ = 1'b1;
    @(negedge clk); ADDR = a2; RW = 1'b1; D_IN = 8'($urandom);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (DONE === 1'b1) begin got = 1'b1; break; end
    end
    vectors++;
    if (got !== 1'b1 || mon_q.size() !== 2) begin
      miscompares++; $display("FAIL b2b_first: got done=%b bytes=%0d expected 1/2", got, mon_q.size());
    end else begin
      vectors++;
      if (mon_q[0] !== {a1, 1'b0, 1'b0} || mon_q[1] !== {d1, 1'b0}) begin
        miscompares++; $display("FAIL b2b_first_bytes: got %h %h expected %h %h",
          mon_q[0], mon_q[1], {a1, 1'b0, 1'b0}, {d1, 1'b0});
      end
    end
    mon_gen++;
    @(negedge clk); REQ = 1'b0;
    vectors++;
    if (BUSY !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy %b expected 1", BUSY); end
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (DONE === 1'b1) begin got = 1'b1; break; end
    end
    dout_exp = rd;
    vectors++;
    if (got !== 1'b1 || mon_q.size() !== 2) begin
      miscompares++; $display("FAIL b2b_second: got done=%b bytes=%0d expected 1/2", got, mon_q.size());
    end else begin
      vectors++;
      if (mon_q[0] !== {a2, 1'b1, 1'b0} || mon_q[1] !== {rd, 1'b1} || D_OUT !== rd) begin
        miscompares++; $display("FAIL b2b_second_bytes: got %h %h dout %h expected %h %h dout %h",
          mon_q[0], mon_q[1], D_OUT, {a2, 1'b1, 1'b0}, {rd, 1'b1}, rd);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic got;
    sl_ack_addr = 1'b1; sl_ack_data = 1'b1; mon_gen++;
    @(negedge clk); ADDR = 7'($urandom); RW = 1'b0; D_IN = 8'($urandom); REQ = 1'b1;
    @(negedge clk); REQ = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (byte_idx == 1 && bitk == 4 && !m_rw) begin got = 1'b1; break; end
    end
    vectors++;
    if (got !== 1'b1) begin miscompares++; $display("FAIL reset_mid_reach: got 0 expected 1"); end
    NRST = 1'b0;
    @(negedge clk);
    vectors++;
    if ({SDA_OUT, SCL_OUT, BUSY, DONE, NACK, ARB_LOST, D_OUT} !== {6'b110000, 8'h00}) begin
      miscompares++; $display("FAIL reset_mid_state: got %b expected %b",
        {SDA_OUT, SCL_OUT, BUSY, DONE, NACK, ARB_LOST, D_OUT}, {6'b110000, 8'h00});
    end
    NRST = 1'b1;
    dout_exp = 8'h00;
    repeat (2) @(negedge clk);
    run_txn("after_reset", 7'($urandom), 1'b1, 8'($urandom), 1'b1, 1'b1, 8'($urandom), 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_data_nack();
    test_stretch();
    test_arbitration();
    test_random();
    test_back_to_back();
    test_read();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
